// File: rtl/prog_clk_divider_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic {IDLE, RUN} state_e;

  localparam int MIN_DIV   = 2;
  localparam int DEF_CNT_W = 16;

  // Default high time for a divisor: half the period, rounded down.
  function automatic logic [31:0] default_high(input logic [31:0] n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// Config/status bundle of prog_clk_divider: master programs the divider, slave is the divider.
// Define PROG_CLK_DIV_SYNC_EN to add the sync phase-realignment strobe.
interface prog_clk_divider_if #(
  parameter int CNT_W = clk_div_pkg::DEF_CNT_W
);
  logic             en;
  logic [CNT_W-1:0] div_in;
  logic [CNT_W-1:0] high_in;
  logic             load;
`ifdef PROG_CLK_DIV_SYNC_EN
  logic             sync;
`endif
  logic             opt;
  logic             tick;
  logic             cfg_err;
  logic [CNT_W-1:0] cur_div;

`ifdef PROG_CLK_DIV_SYNC_EN
  modport master (output en, div_in, high_in, load, sync,
                  input  opt, tick, cfg_err, cur_div);
  modport slave  (input  en, div_in, high_in, load, sync,
                  output opt, tick, cfg_err, cur_div);
`else
  modport master (output en, div_in, high_in, load,
                  input  opt, tick, cfg_err, cur_div);
  modport slave  (input  en, div_in, high_in, load,
                  output opt, tick, cfg_err, cur_div);
`endif
endinterface

// File: rtl/prog_clk_divider_cfg_shadow.sv
// Validates loads, holds the pending divisor/high time and hands it to the active
// set at a period boundary (restart_i) or continuously while idle (idle_i).
module div_cfg_shadow
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int DEF_DIV  = 2,
  parameter int DEF_HIGH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic [CNT_W-1:0] high_i,
  input  logic             restart_i,
  input  logic             idle_i,
  output logic [CNT_W-1:0] active_div_o,
  output logic [CNT_W-1:0] active_high_o,
  output logic             cfg_err_o
);
  logic [CNT_W-1:0] pend_div_q, pend_div_d, pend_high_q, pend_high_d;
  logic [CNT_W-1:0] act_div_q, act_div_d, act_high_q, act_high_d;
  logic             pend_vld_q, pend_vld_d, cfg_err_q, cfg_err_d;
  logic             load_ok;
  logic [CNT_W-1:0] new_high;

  always_comb begin
    new_high  = (high_i == '0) ? CNT_W'(default_high(32'(div_i))) : high_i;
    load_ok   = load_i && (div_i >= CNT_W'(MIN_DIV)) && ((high_i == '0) || (high_i < div_i));
    cfg_err_d = load_i && !load_ok;

    pend_div_d  = pend_div_q;
    pend_high_d = pend_high_q;
    pend_vld_d  = pend_vld_q;
    act_div_d   = act_div_q;
    act_high_d  = act_high_q;

    if (restart_i) begin
      // A load coinciding with the boundary skips the pending stage.
      if (load_ok) begin
        act_div_d  = div_i;
        act_high_d = new_high;
      end else if (pend_vld_q) begin
        act_div_d  = pend_div_q;
        act_high_d = pend_high_q;
      end
      pend_vld_d = 1'b0;
    end else begin
      if (idle_i && pend_vld_q) begin
        act_div_d  = pend_div_q;
        act_high_d = pend_high_q;
        pend_vld_d = 1'b0;
      end
      if (load_ok) begin
        pend_div_d  = div_i;
        pend_high_d = new_high;
        pend_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_div_q  <= CNT_W'(DEF_DIV);
      pend_high_q <= CNT_W'(DEF_HIGH);
      pend_vld_q  <= 1'b0;
      act_div_q   <= CNT_W'(DEF_DIV);
      act_high_q  <= CNT_W'(DEF_HIGH);
      cfg_err_q   <= 1'b0;
    end else begin
      pend_div_q  <= pend_div_d;
      pend_high_q <= pend_high_d;
      pend_vld_q  <= pend_vld_d;
      act_div_q   <= act_div_d;
      act_high_q  <= act_high_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign active_div_o  = act_div_q;
  assign active_high_o = act_high_q;
  assign cfg_err_o     = cfg_err_q;
endmodule

// File: rtl/prog_clk_divider.sv
// Programmable divider: period N>=2 with programmable high time, reconfigured at period boundaries.
// Define PROG_CLK_DIV_SYNC_EN to add a sync input that restarts the period on demand.
module prog_clk_divider
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int DEF_DIV  = 2,
  parameter int DEF_HIGH = 1
) (
  input  logic              clk,
  input  logic              rst,
  prog_clk_divider_if.slave io
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             opt_q, opt_d, tick_q, tick_d;
  logic [CNT_W-1:0] active_div, active_high;
  logic             cfg_err;
  logic             run_en, restart;

  always_comb begin
    run_en  = (state_q == RUN) && io.en;
`ifdef PROG_CLK_DIV_SYNC_EN
    restart = run_en && ((count_q == active_div - CNT_W'(1)) || io.sync);
`else
    restart = run_en && (count_q == active_div - CNT_W'(1));
`endif
    state_d = io.en ? RUN : IDLE;
    count_d = (run_en && !restart) ? count_q + CNT_W'(1) : '0;
    // Outputs lag the counter by one cycle; dropping en kills them immediately.
    opt_d   = run_en && (count_q < active_high);
    tick_d  = run_en && (count_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      opt_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      opt_q   <= opt_d;
      tick_q  <= tick_d;
    end
  end

  div_cfg_shadow #(
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV),
    .DEF_HIGH(DEF_HIGH)
  ) u_shadow (
    .clk          (clk),
    .rst          (rst),
    .load_i       (io.load),
    .div_i        (io.div_in),
    .high_i       (io.high_in),
    .restart_i    (restart),
    .idle_i       (state_q == IDLE),
    .active_div_o (active_div),
    .active_high_o(active_high),
    .cfg_err_o    (cfg_err)
  );

  assign io.opt     = opt_q;
  assign io.tick    = tick_q;
  assign io.cfg_err = cfg_err;
  assign io.cur_div = active_div;
endmodule
